score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 66 ++++++
 rtl/score_display_bin2bcd.sv | 50 +++++
 rtl/score_display.sv | 144 ++++++++++++++
 tb/tb_score_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the score display: learning-mode code, FSM encodings and 7-segment glyphs.
// Segment bit order is bit0=a .. bit6=g, bit7=dp (always off).
package score_display_pkg;

    localparam logic [2:0] LEARN_MODE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [7:0] grade_glyph(input logic [1:0] g);
        case (g)
            2'd0: return SEG_A;
            2'd1: return SEG_B;
            2'd2: return SEG_C;
            default: return SEG_D;
        endcase
    endfunction

    function automatic logic [3:0] bcd_digit(input logic [23:0] b, input logic [2:0] i);
        case (i)
            3'd0: return b[3:0];
            3'd1: return b[7:4];
            3'd2: return b[11:8];
            3'd3: return b[15:12];
            3'd4: return b[19:16];
            3'd5: return b[23:20];
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Sequential double-dabble: 20-bit binary to 6 BCD digits, one shift per cycle.
// The load on start performs the first shift, so done pulses 19 cycles after start.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        done
);
    logic [19:0] shreg;
    logic [23:0] acc;
    logic [23:0] adj;
    logic [4:0]  cnt;
    logic        running;

    always_comb begin
        adj = acc;
        for (int i = 0; i < 6; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {acc, shreg} <= {24'd0, bin} << 1;
                cnt          <= 5'd1;
                running      <= 1'b1;
            end else if (running) begin
                {acc, shreg} <= {adj, shreg} << 1;
                cnt          <= cnt + 5'd1;
                if (cnt == 5'd19) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/score_display.sv
// Captures the mistake count when a song finishes in learning mode, grades it, and
// multiplexes six BCD digits plus a grade glyph across an 8-digit 7-segment display.
module score_display
    import score_display_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int GRADE_A_MAX = 50,
    parameter int GRADE_B_MAX = 200,
    parameter int GRADE_C_MAX = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode,
    input  logic        finished,
    input  logic [40:0] score,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic [1:0]  grade,
    output logic        busy,
    output logic        valid
);
    localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t      state;
    logic        fin_q;
    logic        learn;
    logic        fin_rise;
    logic        conv_start;
    logic        conv_done;
    logic [23:0] bcd;
    logic [19:0] sat_score;
    logic [1:0]  grade_calc;
    logic [CW-1:0] scan_cnt;
    logic        scan_wrap;
    logic [2:0]  digit_idx;
    logic [2:0]  digit_nxt;
    logic        show_nxt;
    logic [7:0]  lit;
    logic [7:0]  glyph;

    assign learn      = (mode == LEARN_MODE);
    assign fin_rise   = learn && finished && !fin_q;
    assign conv_start = fin_rise && (state == ST_IDLE);
    assign sat_score  = (score > 41'd999_999) ? 20'd999_999 : score[19:0];

    always_comb begin
        if (score <= 41'(GRADE_A_MAX))      grade_calc = 2'd0;
        else if (score <= 41'(GRADE_B_MAX)) grade_calc = 2'd1;
        else if (score <= 41'(GRADE_C_MAX)) grade_calc = 2'd2;
        else                                grade_calc = 2'd3;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (sat_score),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // A stale done from an abandoned conversion is ignored because state is no longer CONVERT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            fin_q <= 1'b0;
            grade <= 2'd0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            fin_q <= finished;
            if (!learn) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fin_rise) begin
                            state <= ST_CONVERT;
                            busy  <= 1'b1;
                            grade <= grade_calc;
                        end
                    end
                    ST_CONVERT: begin
                        if (conv_done) begin
                            state <= ST_SHOW;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        state <= ST_SHOW;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Display registers are driven from next-cycle values so they track valid without lag.
    assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
    assign digit_nxt = scan_wrap ? digit_idx + 3'd1 : digit_idx;
    assign show_nxt  = learn && ((state == ST_SHOW) || ((state == ST_CONVERT) && conv_done));

    always_comb begin
        logic seen;
        seen = 1'b0;
        lit  = 8'h01;
        for (int i = 5; i >= 1; i--) begin
            if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            lit[i] = seen;
        end
    end

    always_comb begin
        case (digit_nxt)
            3'd7:    glyph = grade_glyph(grade);
            3'd6:    glyph = SEG_BLANK;
            default: glyph = lit[digit_nxt] ? digit_glyph(bcd_digit(bcd, digit_nxt)) : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            seg_en    <= 8'h00;
            seg_out   <= 8'h00;
        end else begin
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + CW'(1);
            digit_idx <= digit_nxt;
            seg_en    <= show_nxt ? (8'd1 << digit_nxt) : 8'h00;
            seg_out   <= show_nxt ? glyph : 8'h00;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Directed and randomized check of score capture, grading, latency and display scanning.
module tb_score_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        finished;
    logic [40:0] score;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic [1:0]  grade;
    logic        busy;
    logic        valid;

    int n_assert = 0;
    int n_fail   = 0;

    // 0-9 then A b C d
    logic [7:0] glyph_tab [14] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                                   8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E};

    score_display #(.CLK_FREQ(4000), .SCAN_HZ(1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .finished (finished),
        .score    (score),
        .seg_en   (seg_en),
        .seg_out  (seg_out),
        .grade    (grade),
        .busy     (busy),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grade(input logic [40:0] s);
        if (s <= 41'd50)   return 0;
        if (s <= 41'd200)  return 1;
        if (s <= 41'd1000) return 2;
        return 3;
    endfunction

    function automatic int ref_sat(input logic [40:0] s);
        return (s > 41'd999_999) ? 999_999 : int'(s[19:0]);
    endfunction

    function automatic logic [7:0] ref_seg(input int idx, input int sat, input int g);
        int p;
        if (idx == 7) return glyph_tab[10 + g];
        if (idx == 6) return 8'h00;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (idx > 0 && sat < p) return 8'h00;
        return glyph_tab[(sat / p) % 10];
    endfunction

    task automatic capture(input logic [40:0] s);
        @(negedge clk);
        mode     = 3'b000;
        finished = 1'b0;
        @(negedge clk);
        mode  = 3'b100;
        score = s;
        @(negedge clk);
        finished = 1'b1;
    endtask

    task automatic check_latency(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk({tag, " busy phase"}, {62'd0, busy, valid}, 64'd2);
        end
        @(negedge clk);
        chk({tag, " result ready"}, {62'd0, busy, valid}, 64'd1);
    endtask

    task automatic check_display(input string tag, input logic [40:0] s);
        int   sat;
        int   g;
        int   idx;
        logic [7:0] seen;
        sat  = ref_sat(s);
        g    = ref_grade(s);
        seen = 8'h00;
        chk({tag, " grade"}, 64'(grade), 64'(g));
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            chk({tag, " one-hot"}, 64'($countones(seg_en)), 64'd1);
            idx = 0;
            for (int b = 0; b < 8; b++) if (seg_en[b]) idx = b;
            seen[idx] = 1'b1;
            chk({tag, " seg_out"}, 64'(seg_out), 64'(ref_seg(idx, sat, g)));
        end
        chk({tag, " all digits scanned"}, 64'(seen), 64'hFF);
    endtask

    task automatic full_run(input string tag, input logic [40:0] s);
        capture(s);
        check_latency(tag);
        check_display(tag, s);
    endtask

    initial begin
        logic [40:0] rs;
        logic [40:0] bounds [8];
        bounds = '{41'd50, 41'd51, 41'd200, 41'd201, 41'd1000, 41'd1001, 41'd999_999, 41'd1_000_000};

        rst = 1'b1; mode = 3'b000; finished = 1'b0; score = '0;
        repeat (3) @(negedge clk);
        chk("reset seg_en", 64'(seg_en), 64'd0);
        chk("reset seg_out", 64'(seg_out), 64'd0);
        chk("reset grade", 64'(grade), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        rst = 1'b0;

        full_run("score37", 41'd37);
        full_run("score5M", 41'd5_000_000);
        full_run("score200", 41'd200);
        full_run("score201", 41'd201);
        full_run("score0", 41'd0);

        // finished falling while shown keeps the result
        finished = 1'b0;
        repeat (5) @(negedge clk);
        chk("show holds after finished falls", {62'd0, busy, valid}, 64'd1);

        // second edge during conversion is ignored
        capture(41'd37);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reedge busy phase", {62'd0, busy, valid}, 64'd2);
            if (i == 4) finished = 1'b0;
            if (i == 8) begin finished = 1'b1; score = 41'd999; end
        end
        @(negedge clk);
        chk("reedge result ready", {62'd0, busy, valid}, 64'd1);
        check_display("reedge", 41'd37);

        // mode leaves learning during conversion
        capture(41'd500);
        repeat (6) @(negedge clk);
        mode = 3'b000;
        @(negedge clk);
        chk("abort convert busy/valid", {62'd0, busy, valid}, 64'd0);
        chk("abort convert seg_en", 64'(seg_en), 64'd0);

        // mode leaves learning while showing
        full_run("score42", 41'd42);
        mode = 3'b000;
        @(negedge clk);
        chk("abort show busy/valid", {62'd0, busy, valid}, 64'd0);
        chk("abort show seg_en", 64'(seg_en), 64'd0);
        chk("abort show seg_out", 64'(seg_out), 64'd0);

        // reset on the tenth conversion cycle
        capture(41'd777);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        finished = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy/valid", {62'd0, busy, valid}, 64'd0);
        chk("midreset seg_en", 64'(seg_en), 64'd0);
        chk("midreset seg_out", 64'(seg_out), 64'd0);
        chk("midreset grade", 64'(grade), 64'd0);
        full_run("after reset", 41'd123_456);

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(0, 3))
                0: rs = 41'($urandom_range(0, 1100));
                1: rs = 41'($urandom_range(0, 999_999));
                2: rs = 41'({$urandom, $urandom});
                default: rs = bounds[$urandom_range(0, 7)];
            endcase
            full_run("random", rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
